disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Time-multiplexing scan controller that shares one external hex-nibble-to-BCD decoder (4-bit in, 8-bit two-digit BCD out) across NUM_NIBBLES display digits. It accepts a display word through a valid/ready handshake, double-buffers it so frames never tear, and sequences the nibbles MSB-first through the decoder. It drives a one-hot digit strobe, the registered BCD pattern for the active digit, and a per-frame done pulse. It sits between the register/status logic and the display pins.

## Interface
- NUM_NIBBLES, 4, digits scanned; ≥1
- DWELL_CYCLES, 1000, cycles each digit is strobed; ≥1
- BLANK_CYCLES, 16, dark cycles after each digit; 0 skips BLANK
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  scan run; low forces IDLE
- upd_valid  in  1  new display word offered
- upd_ready  out  1  pending buffer empty
- upd_data  in  4*NUM_NIBBLES  display word; nibble i = bits [4i+3:4i]
- dec_bin  out  4  nibble to shared decoder (registered)
- dec_bcd  in  8  decoder result, combinational from dec_bin
- digit_sel  out  NUM_NIBBLES  one-hot active-high digit strobe
- seg_bcd  out  8  registered BCD for strobed digit
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation
- Reset (rst_n=0 at edge): state IDLE, idx=NUM_NIBBLES-1, dec_bin=0, seg_bcd=0, digit_sel=0, frame_done=0, shadow=0, pending empty, upd_ready=1.
- Buffers: pending (from handshake) and shadow (displayed). Capture into pending when upd_valid&&upd_ready. upd_ready = !pending_full.
- Pending→shadow transfer: any IDLE cycle with pending full, or at frame boundary. The transfer empties pending, and upd_ready rises the next cycle. Data accepted after the boundary cycle waits for the next frame.
- FSM states: IDLE, SETUP, SHOW, BLANK.
  - IDLE → SETUP when enable=1. idx=NUM_NIBBLES-1. dec_bin loads shadow[idx] on the transition.
  - SETUP, 1 cycle: seg_bcd<=dec_bcd and digit_sel<=onehot(idx) at exit, then go to SHOW. Dwell counter loads DWELL_CYCLES-1.
  - SHOW, DWELL_CYCLES cycles: outputs held. At counter zero, go to BLANK (load BLANK_CYCLES-1, digit_sel<=0), or directly to the next digit if BLANK_CYCLES=0.
  - BLANK: digit_sel=0, seg_bcd held.
  - Next digit: if idx=0, this is the frame boundary. Pulse frame_done, do the shadow transfer, set idx=NUM_NIBBLES-1, and dec_bin loads the new shadow MSB nibble. Otherwise idx decrements and dec_bin loads shadow[idx-1]. Either way, go to SETUP.
- enable low in any non-IDLE state: next cycle IDLE, digit_sel=0, idx=NUM_NIBBLES-1, no frame_done. Pending is kept. Re-enable restarts at the MSB.
- Counter width: clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).

## Timing
- Frame length: NUM_NIBBLES*(1+DWELL_CYCLES+BLANK_CYCLES) cycles.
- Decoder latency: 0 (combinational). seg_bcd is valid on the first SHOW cycle, together with digit_sel.
- digit_sel is never asserted in SETUP, BLANK or IDLE. At most one bit is high at any time.
- Reset mid-frame clears everything, pending included, in one cycle.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: in SETUP, a digit idx>0 whose nibble and all higher nibbles are zero is suppressed. SHOW keeps digit_sel=0 and loads seg_bcd=0. Timing is unchanged. Digit 0 is always shown.
  - Undefined: every digit is strobed.

## Structure
- Package disp_pkg holds:
  - the state enum
  - default parameter constants
  - the counter-width function
  - the onehot(idx) function
- Sub-module scan_timer: loadable down-counter with zero flag, shared by SHOW and BLANK.
- The decoder is external and is not instantiated here.

## Test plan
All cases use NUM_NIBBLES=4, DWELL_CYCLES=3, BLANK_CYCLES=1; frame = 20 cycles.
- Reset: rst_n=0 for 2 cycles → all outputs 0, upd_ready=1.
- Basic frame: load 0x1A3F in IDLE, then enable=1 → SHOW phases give (digit_sel, seg_bcd):
  - 1000, 0x01
  - 0100, 0x10
  - 0010, 0x03
  - 0001, 0x15
  - frame_done fires at cycle 20.
- Mid-frame update: offer 0x9999 at frame cycle 5 → accepted, upd_ready=0 until the boundary. The current frame still shows 1A3F; the next frame shows 0x09 on all digits.
- Enable drop: enable=0 during SHOW of digit 2 → next cycle digit_sel=0 in IDLE. Re-enable → digit 3 first, and no frame_done for the aborted frame.
- Mid-frame reset: rst_n=0 during SHOW with pending full → next cycle outputs 0, upd_ready=1.
- Leading-zero blanking (LEADING_ZERO_BLANK_EN defined):
  - 0x0005 → digits 3–1 dark, digit 0 = 0x05.
  - 0x0000 → only digit 0 strobed, 0x00.
  - 0x0A00 → digit 2 = 0x10, digit 1 = 0x00 shown.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the display scan controller: scan state encoding,
// default timing constants, counter sizing and digit-strobe decoding.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } scan_state_t;

    localparam int DEF_NUM_NIBBLES  = 4;
    localparam int DEF_DWELL_CYCLES = 1000;
    localparam int DEF_BLANK_CYCLES = 16;
    localparam int MAX_NIBBLES      = 32;

    // Width of a down-counter that must hold the longer of the two phase loads.
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = (dwell > blank) ? dwell : blank;
        return $clog2(m + 1);
    endfunction

    function automatic logic [MAX_NIBBLES-1:0] onehot(input int idx);
        logic [MAX_NIBBLES-1:0] one;
        one = 1;
        return one << idx;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with a zero flag; times both the SHOW dwell and the BLANK gap.
module scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed display scan controller sharing one external nibble-to-BCD decoder.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_NIBBLES  = DEF_NUM_NIBBLES,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [4*NUM_NIBBLES-1:0] upd_data,
    output logic [3:0]               dec_bin,
    input  logic [7:0]               dec_bcd,
    output logic [NUM_NIBBLES-1:0]   digit_sel,
    output logic [7:0]               seg_bcd,
    output logic                     frame_done,
    output logic [1:0]               dbg_state
);

    localparam int CNT_W = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_NIBBLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    // Update handshake: a word transfers on any cycle where upd_valid && upd_ready.
    // upd_ready depends only on the pending buffer, never on upd_valid.

    scan_state_t state, state_next;

    logic [IDX_W-1:0]         idx, idx_dec;
    logic [4*NUM_NIBBLES-1:0] pending, shadow, shadow_next;
    logic                     pending_full;

    logic             start, setup_exit, blank_enter, next_digit, abort;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             frame_boundary, transfer, suppress;
    logic [3:0]       msb_nib, lower_nib;

    scan_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        setup_exit  = 1'b0;
        blank_enter = 1'b0;
        next_digit  = 1'b0;
        abort       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        if (state != ST_IDLE && !enable) begin
            state_next = ST_IDLE;
            abort      = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_next = ST_SETUP;
                        start      = 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_next = ST_SHOW;
                    setup_exit = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = DWELL_LOAD;
                end
                ST_SHOW: begin
                    if (tmr_zero) begin
                        if (BLANK_CYCLES > 0) begin
                            state_next  = ST_BLANK;
                            blank_enter = 1'b1;
                            tmr_load    = 1'b1;
                            tmr_val     = BLANK_LOAD;
                        end else begin
                            state_next = ST_SETUP;
                            next_digit = 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (tmr_zero) begin
                        state_next = ST_SETUP;
                        next_digit = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign dbg_state      = state;
    assign upd_ready      = !pending_full;
    assign frame_boundary = next_digit && (idx == '0);
    // Shadow only changes between frames, so a displayed frame never mixes two words.
    assign transfer       = pending_full && ((state == ST_IDLE) || frame_boundary);
    assign shadow_next    = transfer ? pending : shadow;
    assign msb_nib        = shadow_next[4*NUM_NIBBLES-1 -: 4];
    assign idx_dec        = (idx == '0) ? '0 : idx - IDX_W'(1);
    assign lower_nib      = 4'(shadow >> (4 * int'(idx_dec)));

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
    assign suppress = (idx != '0) && ((shadow >> (4 * int'(idx))) == '0);
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= IDX_LAST;
            dec_bin      <= '0;
            seg_bcd      <= '0;
            digit_sel    <= '0;
            frame_done   <= 1'b0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (upd_valid && upd_ready) begin
                pending      <= upd_data;
                pending_full <= 1'b1;
            end
            if (transfer) begin
                shadow       <= pending;
                pending_full <= 1'b0;
            end
            frame_done <= frame_boundary;
            if (abort) begin
                digit_sel <= '0;
                idx       <= IDX_LAST;
            end
            if (start) begin
                idx     <= IDX_LAST;
                dec_bin <= msb_nib;
            end
            if (setup_exit) begin
                seg_bcd   <= suppress ? 8'h00 : dec_bcd;
                digit_sel <= suppress ? '0 : NUM_NIBBLES'(onehot(int'(idx)));
            end
            if (blank_enter) begin
                digit_sel <= '0;
            end
            if (next_digit) begin
                digit_sel <= '0;
                if (idx == '0) begin
                    idx     <= IDX_LAST;
                    dec_bin <= msb_nib;
                end else begin
                    idx     <= idx_dec;
                    dec_bin <= lower_nib;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed frames from the test plan plus randomized traffic,
// all checked against a frame-timeline reference model.
module tb_disp_scan_ctrl;

    localparam int N = 4;
    localparam int D = 3;
    localparam int B = 1;
    localparam int P = 1 + D + B;
    localparam int F = N * P;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            upd_valid;
    logic            upd_ready;
    logic [4*N-1:0]  upd_data;
    logic [3:0]      dec_bin;
    logic [7:0]      dec_bcd;
    logic [N-1:0]    digit_sel;
    logic [7:0]      seg_bcd;
    logic            frame_done;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit              m_run;
    int              m_t;
    logic [4*N-1:0]  m_shadow;
    logic [4*N-1:0]  exp_q[$];
    logic [7:0]      m_seg;
    bit              m_fd;
    logic [3:0]      m_decbin;

    disp_scan_ctrl #(
        .NUM_NIBBLES  (N),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .dec_bin    (dec_bin),
        .dec_bcd    (dec_bcd),
        .digit_sel  (digit_sel),
        .seg_bcd    (seg_bcd),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input logic [3:0] v);
        int tens;
        int ones;
        tens = int'(v) / 10;
        ones = int'(v) % 10;
        return 8'((tens << 4) | ones);
    endfunction

    // External shared decoder
    always_comb dec_bcd = bcd2(dec_bin);

    function automatic logic [3:0] nib(input logic [4*N-1:0] w, input int d);
        return 4'(w >> (4 * d));
    endfunction

    function automatic bit dark(input logic [4*N-1:0] w, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d > 0) && ((w >> (4 * d)) == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model advance for one rising edge, using the inputs the DUT sees at that edge.
    task automatic model_edge();
        bit full_pre;
        int digit;
        int phase;
        full_pre = (exp_q.size() != 0);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_shadow = '0; exp_q.delete();
            m_seg = '0; m_fd = 0; m_decbin = '0;
            return;
        end
        m_fd = 0;
        if (upd_valid && !full_pre) exp_q.push_back(upd_data);
        if (!m_run) begin
            if (full_pre) m_shadow = exp_q.pop_front();
            if (enable) begin
                m_run = 1;
                m_t   = 0;
            end
        end else if (!enable) begin
            m_run = 0;
        end else begin
            m_t++;
            if (m_t == F) begin
                m_t  = 0;
                m_fd = 1;
                if (full_pre) m_shadow = exp_q.pop_front();
            end
        end
        if (m_run) begin
            digit = N - 1 - m_t / P;
            phase = m_t % P;
            if (phase == 0) m_decbin = nib(m_shadow, digit);
            if (phase == 1) m_seg = dark(m_shadow, digit) ? 8'h00 : bcd2(nib(m_shadow, digit));
        end
    endtask

    function automatic logic [N-1:0] exp_sel();
        int digit;
        int phase;
        if (!m_run) return '0;
        digit = N - 1 - m_t / P;
        phase = m_t % P;
        if (phase >= 1 && phase <= D && !dark(m_shadow, digit)) return N'(1 << digit);
        return '0;
    endfunction

    task automatic compare_all();
        check_eq("digit_sel",  32'(digit_sel),  32'(exp_sel()));
        check_eq("seg_bcd",    32'(seg_bcd),    32'(m_seg));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("upd_ready",  32'(upd_ready),  32'(exp_q.size() == 0));
        check_eq("dec_bin",    32'(dec_bin),    32'(m_decbin));
        check_eq("onehot",     32'($countones(digit_sel) <= 1), 32'd1);
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic load_word(input logic [4*N-1:0] w);
        upd_valid = 1'b1;
        upd_data  = w;
        step();
        upd_valid = 1'b0;
    endtask

    logic [3:0]  tbl_sel [4];
    logic [7:0]  tbl_seg [4];

    initial begin
        tbl_sel[0] = 4'b1000; tbl_seg[0] = 8'h01;
        tbl_sel[1] = 4'b0100; tbl_seg[1] = 8'h10;
        tbl_sel[2] = 4'b0010; tbl_seg[2] = 8'h03;
        tbl_sel[3] = 4'b0001; tbl_seg[3] = 8'h15;

        rst_n = 1'b0; enable = 1'b0; upd_valid = 1'b0; upd_data = '0;
        m_run = 0; m_t = 0; m_shadow = '0; m_seg = '0; m_fd = 0; m_decbin = '0;
        step();
        step();
        check_eq("rst_digit_sel", 32'(digit_sel), 32'd0);
        check_eq("rst_seg_bcd",   32'(seg_bcd),   32'd0);
        check_eq("rst_upd_ready", 32'(upd_ready), 32'd1);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Basic frame 0x1A3F, then 0x9999 offered mid-frame
        load_word(16'h1A3F);
        step();
        enable = 1'b1;
        for (int c = 0; c < 2 * F; c++) begin
            upd_valid = (c == 6);
            upd_data  = 16'h9999;
            step();
            if (c < F && c % P == 1) begin
                check_eq("basic_sel", 32'(digit_sel), 32'(tbl_sel[c / P]));
                check_eq("basic_seg", 32'(seg_bcd),   32'(tbl_seg[c / P]));
            end
            if (c == 10) check_eq("upd_hold", 32'(upd_ready), 32'd0);
            if (c == F - 1) check_eq("fd_early", 32'(frame_done), 32'd0);
            if (c == F) check_eq("fd_boundary", 32'(frame_done), 32'd1);
            if (c > F && c % P == 1) check_eq("next_frame_seg", 32'(seg_bcd), 32'h09);
        end
        upd_valid = 1'b0;

        // Enable drop during SHOW of digit 2, then restart at the MSB
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int c = 0; c < 8; c++) step();
        enable = 1'b0;
        step();
        check_eq("drop_sel", 32'(digit_sel), 32'd0);
        enable = 1'b1;
        step();
        step();
        check_eq("restart_sel", 32'(digit_sel), 32'b1000);
        check_eq("restart_fd", 32'(frame_done), 32'd0);

        // Reset mid-frame with pending full
        load_word(16'h4321);
        step();
        rst_n = 1'b0;
        step();
        check_eq("mrst_sel",   32'(digit_sel), 32'd0);
        check_eq("mrst_seg",   32'(seg_bcd),   32'd0);
        check_eq("mrst_ready", 32'(upd_ready), 32'd1);
        rst_n  = 1'b1;
        enable = 1'b0;
        step();

`ifdef LEADING_ZERO_BLANK_EN
        load_word(16'h0005);
        step();
        enable = 1'b1;
        for (int c = 0; c < F; c++) begin
            step();
            if (c == 1)  check_eq("lzb_d3_dark", 32'(digit_sel), 32'd0);
            if (c == 16) check_eq("lzb_d0_sel",  32'(digit_sel), 32'd1);
            if (c == 16) check_eq("lzb_d0_seg",  32'(seg_bcd),   32'h05);
        end
        enable = 1'b0;
        step();
        load_word(16'h0A00);
        step();
        enable = 1'b1;
        for (int c = 0; c < F; c++) begin
            step();
            if (c == 6)  check_eq("lzb_d2_seg", 32'(seg_bcd),   32'h10);
            if (c == 11) check_eq("lzb_d1_sel", 32'(digit_sel), 32'b0010);
        end
        enable = 1'b0;
        step();
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            rst_n     = ($urandom_range(0, 399) != 0);
            enable    = ($urandom_range(0, 59) != 0);
            upd_valid = ($urandom_range(0, 7) == 0);
            upd_data  = 16'($urandom) & mask;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
